uart_core: RTL and testbench
============================

Name: uart_core

Overview:
Full-duplex UART transmitter and receiver sharing one 16x oversampling tick generator.
- Frame format fixed at elaboration: data width, parity mode, stop-bit count.
- Baud rate set at run time through a divisor input, so one bitstream serves several link speeds.
- Sits between the host-side byte/command logic (valid/ready streams) and the board RS-232 pins.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits generated by TX, legal 1 or 2 (RX checks only the first)
DIV_WIDTH, 16, width of baud_div

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_div  in  DIV_WIDTH  oversample tick every baud_div+1 clocks; bit time = 16*(baud_div+1) clocks
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle, will accept
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data/rx_parity_err valid, held until consumed
rx_ready  in  1  consumer accepts rx_data
rx_parity_err  out  1  parity mismatch on word in rx_data, qualified by rx_valid
rx_frame_err  out  1  one-cycle pulse: first stop bit sampled low
rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid still high

Behaviour:
- Reset: txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error outputs 0, both FSMs IDLE, tick counter 0, RX synchroniser flops = 1.
- Tick generator: free-running counter. When count >= baud_div: emit tick, clear counter; else increment. A baud_div change takes effect no later than the next wrap. baud_div=0 gives a tick every clock.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Accept on tx_valid & tx_ready: latch tx_data, clear 4-bit phase counter and bit index.
  - tx_ready falls the cycle after acceptance; txd goes 0 the same cycle.
  - Each bit lasts exactly 16 ticks.
  - DATA shifts DATA_BITS bits, LSB first.
  - PARITY state only when PARITY != 0. Bit = XOR of data bits (even mode), inverted (odd mode).
  - STOP lasts STOP_BITS*16 ticks, txd=1. Then IDLE, tx_ready=1.
  - Back-to-back: tx_valid held high gives the next start bit immediately after the last stop tick; no idle gap.
- RX input: rxd passes a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: falling edge of the synchronised rxd -> START, phase counter cleared.
  - START: after 8 ticks, sample. If low -> DATA. If high -> IDLE (glitch rejected, no outputs).
  - Bit sampling: every 16 ticks thereafter, at bit centre. Data shifted in LSB first, then parity if enabled, then first stop bit.
  - Stop bit high, rx_valid=0: load rx_data, set rx_parity_err, raise rx_valid -> IDLE.
  - Stop bit high, rx_valid=1: pulse rx_overrun, discard new word, keep old word -> IDLE.
  - Stop bit low: pulse rx_frame_err, do not deliver -> BREAK. BREAK waits for synchronised rxd=1, then -> IDLE.
- rx_valid clears the cycle after rx_valid & rx_ready.
- Simultaneous consume and frame completion in the same cycle: the new word loads, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 clock after the stop-bit sample tick.
- rst_n low mid-frame: both FSMs abort immediately to reset values. No partial word is delivered.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit, after rxd). When loopback=1, the RX path takes the internal TX serial stream in place of the synchronised rxd, and the txd pin is forced to 1.
- Undefined: port absent, rxd always used.

Test Plan:
- Reset with rst_n=0 mid-transmission -> txd=1, tx_ready=1, rx_valid=0 within the same cycle (asynchronous). After release, next frame is clean.
- PARITY=2, baud_div=3, send 0xA5 -> txd: start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 64 clocks. tx_ready low for 11*64 clocks.
- Drive rxd frame 0x3C with correct odd parity (PARITY=1), baud_div=0 -> rx_valid=1, rx_data=0x3C, rx_parity_err=0. Flip the parity bit -> same data with rx_parity_err=1.
- 0x55 frame with stop bit low -> one rx_frame_err pulse, rx_valid stays 0. rxd held low 40 bit times -> no further outputs until rxd returns high.
- Two frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, one rx_overrun pulse. Repeat with rx_ready pulsed at the second frame's completion cycle -> rx_data=0x22, no overrun.
- 4-clock low glitch on rxd with baud_div=3 -> no output. With UART_LOOPBACK_EN and loopback=1, send 0x9E -> rx_data=0x9E, txd pin stays 1.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: full-duplex UART sharing one 16x oversampling tick generator.
// Define UART_LOOPBACK_EN to add the loopback port (TX stream fed to RX).
module uart_core #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY == 1);
  localparam logic       HAS_PAR   = (PARITY != 0);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;

  assign tick = (div_cnt >= baud_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_WIDTH'(1);
  end

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [3:0]           tx_phase, tx_phase_n;
  logic [3:0]           tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line, tx_line_n;
  logic                 tx_last;

  assign tx_last = tick && (tx_phase == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_phase <= tx_phase_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
    end
  end

  // Ready also during the final stop tick so a held tx_valid leaves no gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_phase_n = tx_phase;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_ready   = (tx_state == TX_IDLE) ||
                 (tx_state == TX_STOP && tx_last && tx_idx == LAST_STOP);
    if (tx_valid && tx_ready) begin
      tx_state_n = TX_START;
      tx_phase_n = '0;
      tx_idx_n   = '0;
      tx_shift_n = tx_data;
      tx_par_n   = (^tx_data) ^ ODD;
    end else if (tick) begin
      tx_phase_n = tx_phase + 4'd1;
      if (tx_last) begin
        case (tx_state)
          TX_START: tx_state_n = TX_DATA;
          TX_DATA: begin
            tx_shift_n = tx_shift >> 1;
            if (tx_idx == LAST_DATA) begin
              tx_idx_n   = '0;
              tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_idx_n = tx_idx + 4'd1;
            end
          end
          TX_PARITY: tx_state_n = TX_STOP;
          TX_STOP: begin
            if (tx_idx == LAST_STOP) tx_state_n = TX_IDLE;
            else                     tx_idx_n   = tx_idx + 4'd1;
          end
          default: tx_state_n = TX_IDLE;
        endcase
      end
    end
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_shift_n[0];
      TX_PARITY: tx_line_n = tx_par_n;
      default:   tx_line_n = 1'b1;
    endcase
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  rx_state_t            rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_in, rx_prev;
  logic [3:0]           rx_phase, rx_phase_n;
  logic [3:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_data_n;
  logic                 rx_par, rx_par_n;
  logic                 rx_valid_n, rx_perr_n, rx_ferr_n, rx_ovr_n;
  logic                 rx_mid;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : rx_s2;
  assign txd   = loopback ? 1'b1 : tx_line;
`else
  assign rx_in = rx_s2;
  assign txd   = tx_line;
`endif

  assign rx_mid = tick && (rx_phase == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_phase      <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_s1         <= rxd;
      rx_s2         <= rx_s1;
      rx_prev       <= rx_in;
      rx_state      <= rx_state_n;
      rx_phase      <= rx_phase_n;
      rx_idx        <= rx_idx_n;
      rx_shift      <= rx_shift_n;
      rx_par        <= rx_par_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      rx_parity_err <= rx_perr_n;
      rx_frame_err  <= rx_ferr_n;
      rx_overrun    <= rx_ovr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_phase_n = rx_phase;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_data_n  = rx_data;
    rx_perr_n  = rx_parity_err;
    rx_valid_n = rx_valid && !rx_ready;
    rx_ferr_n  = 1'b0;
    rx_ovr_n   = 1'b0;
    if (tick) rx_phase_n = rx_phase + 4'd1;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_in) begin
          rx_state_n = RX_START;
          rx_phase_n = '0;
        end
      end
      RX_START: begin
        if (tick && rx_phase == 4'd7) begin
          rx_phase_n = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_n = {rx_in, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == LAST_DATA) begin
            rx_idx_n   = '0;
            rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_n = rx_idx + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) begin
          rx_par_n   = rx_in;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          if (!rx_in) begin
            rx_ferr_n  = 1'b1;
            rx_state_n = RX_BREAK;
          end else begin
            rx_state_n = RX_IDLE;
            if (rx_valid && !rx_ready) begin
              rx_ovr_n = 1'b1;
            end else begin
              rx_data_n  = rx_shift;
              rx_perr_n  = HAS_PAR && ((^rx_shift) ^ rx_par ^ ODD);
              rx_valid_n = 1'b1;
            end
          end
        end
      end
      RX_BREAK: if (rx_in) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core, an even-parity instance
// for TX/glitch/loopback and an odd-parity instance for RX framing.
module tb_uart_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] div_e = 16'd3;
  logic [7:0]  tdata_e = 8'h00;
  logic        tv_e = 1'b0, tr_e, txd_e, rxd_e = 1'b1;
  logic [7:0]  rdata_e;
  logic        rv_e, rr_e = 1'b0, pe_e, fe_e, ov_e;

  logic [15:0] div_o = 16'd0;
  logic [7:0]  tdata_o = 8'h00;
  logic        tv_o = 1'b0, tr_o, txd_o, rxd_o = 1'b1;
  logic [7:0]  rdata_o;
  logic        rv_o, rr_o = 1'b0, pe_o, fe_o, ov_o;
`ifdef UART_LOOPBACK_EN
  logic        lb_e = 1'b0;
  logic        lb_o = 1'b0;
`endif

  uart_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16)) u_even (
    .clk(clk), .rst_n(rst_n), .baud_div(div_e),
    .tx_data(tdata_e), .tx_valid(tv_e), .tx_ready(tr_e), .txd(txd_e),
    .rxd(rxd_e),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_e),
`endif
    .rx_data(rdata_e), .rx_valid(rv_e), .rx_ready(rr_e),
    .rx_parity_err(pe_e), .rx_frame_err(fe_e), .rx_overrun(ov_e)
  );

  uart_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) u_odd (
    .clk(clk), .rst_n(rst_n), .baud_div(div_o),
    .tx_data(tdata_o), .tx_valid(tv_o), .tx_ready(tr_o), .txd(txd_o),
    .rxd(rxd_o),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_o),
`endif
    .rx_data(rdata_o), .rx_valid(rv_o), .rx_ready(rr_o),
    .rx_parity_err(pe_o), .rx_frame_err(fe_o), .rx_overrun(ov_o)
  );

  int fe_cnt_e = 0, ov_cnt_e = 0, fe_cnt_o = 0, ov_cnt_o = 0;
  always @(negedge clk) begin
    if (fe_e) fe_cnt_e++;
    if (ov_e) ov_cnt_e++;
    if (fe_o) fe_cnt_o++;
    if (ov_o) ov_cnt_o++;
  end

  // Cycles spent until txd_e equals v.
  task automatic wait_txd(input logic v, input int lim, output int n);
    n = 0;
    while (txd_e !== v && n < lim) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Drives one 16-clock-per-bit frame on rxd_o (baud_div = 0);
  // rr_o is high for the single cycle following negedge number pulse_at.
  task automatic send_rx(input logic [7:0] d, input logic p,
                         input logic s, input int pulse_at);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 176; i++) begin
      rxd_o = f[i/16];
      rr_o  = (i == pulse_at);
      @(negedge clk);
    end
    rr_o = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (txd_e !== 1'b1) begin errors++; $display("FAIL rst_txd got=%b exp=1", txd_e); end
    checks++; if (tr_e !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got=%b exp=1", tr_e); end
    checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got=%b exp=0", rv_o); end
    checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL rst_rx_data got=%h exp=00", rdata_o); end
    checks++; if (pe_o !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b exp=0", pe_o); end
    checks++; if (fe_o !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", fe_o); end
    checks++; if (ov_o !== 1'b0) begin errors++; $display("FAIL rst_ovr got=%b exp=0", ov_o); end
    rst_n = 1'b1;
    @(negedge clk);
    tdata_e = 8'h00; tv_e = 1'b1;
    @(negedge clk);
    tv_e = 1'b0; rxd_o = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (txd_e !== 1'b0) begin errors++; $display("FAIL mid_txd got=%b exp=0", txd_e); end
    checks++; if (tr_e !== 1'b0) begin errors++; $display("FAIL mid_tx_ready got=%b exp=0", tr_e); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (txd_e !== 1'b1) begin errors++; $display("FAIL async_txd got=%b exp=1", txd_e); end
    checks++; if (tr_e !== 1'b1) begin errors++; $display("FAIL async_tx_ready got=%b exp=1", tr_e); end
    checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL async_rx_valid got=%b exp=0", rv_o); end
    rxd_o = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL post_rst_rx_valid got=%b exp=0", rv_o); end
    checks++; if (fe_cnt_o !== 0) begin errors++; $display("FAIL post_rst_ferr got=%0d exp=0", fe_cnt_o); end
  endtask

  task automatic test_tx;
    logic [10:0] fr;
    int n;
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    tdata_e = 8'hA5; tv_e = 1'b1;
    @(negedge clk);
    tv_e = 1'b0;
    checks++; if (tr_e !== 1'b0) begin errors++; $display("FAIL tx_ready_fall got=%b exp=0", tr_e); end
    checks++; if (txd_e !== 1'b0) begin errors++; $display("FAIL tx_start got=%b exp=0", txd_e); end
    wait_txd(1'b1, 100, n);
    checks++; if (n < 61 || n > 64) begin errors++; $display("FAIL tx_start_len got=%0d exp=61..64", n); end
    wait_txd(1'b0, 100, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL tx_bit0_len got=%0d exp=64", n); end
    for (int j = 2; j <= 10; j++) begin
      repeat (32) @(negedge clk);
      checks++;
      if (txd_e !== fr[j]) begin
        errors++; $display("FAIL tx_bit%0d got=%b exp=%b", j, txd_e, fr[j]);
      end
      if (j < 10) repeat (32) @(negedge clk);
    end
    checks++; if (tr_e !== 1'b0) begin errors++; $display("FAIL tx_ready_stop got=%b exp=0", tr_e); end
    repeat (32) @(negedge clk);
    checks++; if (tr_e !== 1'b1) begin errors++; $display("FAIL tx_ready_end got=%b exp=1", tr_e); end
    checks++; if (txd_e !== 1'b1) begin errors++; $display("FAIL tx_idle got=%b exp=1", txd_e); end
  endtask

  task automatic test_back_to_back;
    int n;
    tdata_e = 8'hFF; tv_e = 1'b1;
    @(negedge clk);
    wait_txd(1'b1, 100, n);
    wait_txd(1'b0, 700, n);
    checks++; if (n !== 512) begin errors++; $display("FAIL b2b_data_len got=%0d exp=512", n); end
    wait_txd(1'b1, 100, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL b2b_par_len got=%0d exp=64", n); end
    wait_txd(1'b0, 100, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL b2b_stop_len got=%0d exp=64", n); end
    tv_e = 1'b0;
    checks++; if (tr_e !== 1'b0) begin errors++; $display("FAIL b2b_second_busy got=%b exp=0", tr_e); end
    n = 0;
    while (tr_e !== 1'b1 && n < 800) begin n++; @(negedge clk); end
    checks++; if (tr_e !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", tr_e); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_parity;
    send_rx(8'h3C, 1'b1, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rv_o !== 1'b1) begin errors++; $display("FAIL rx_ok_valid got=%b exp=1", rv_o); end
    checks++; if (rdata_o !== 8'h3C) begin errors++; $display("FAIL rx_ok_data got=%h exp=3c", rdata_o); end
    checks++; if (pe_o !== 1'b0) begin errors++; $display("FAIL rx_ok_perr got=%b exp=0", pe_o); end
    rr_o = 1'b1;
    @(negedge clk);
    rr_o = 1'b0;
    checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL rx_consume got=%b exp=0", rv_o); end
    send_rx(8'h3C, 1'b0, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rv_o !== 1'b1) begin errors++; $display("FAIL rx_bad_valid got=%b exp=1", rv_o); end
    checks++; if (rdata_o !== 8'h3C) begin errors++; $display("FAIL rx_bad_data got=%h exp=3c", rdata_o); end
    checks++; if (pe_o !== 1'b1) begin errors++; $display("FAIL rx_bad_perr got=%b exp=1", pe_o); end
    rr_o = 1'b1;
    @(negedge clk);
    rr_o = 1'b0;
  endtask

  task automatic test_frame_err;
    int fb, ob;
    fb = fe_cnt_o; ob = ov_cnt_o;
    send_rx(8'h55, 1'b1, 1'b0, -1);
    repeat (640) @(negedge clk);
    checks++; if (fe_cnt_o - fb !== 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt_o - fb); end
    checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL ferr_valid got=%b exp=0", rv_o); end
    rxd_o = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt_o - fb !== 1) begin errors++; $display("FAIL break_pulses got=%0d exp=1", fe_cnt_o - fb); end
    checks++; if (ov_cnt_o - ob !== 0) begin errors++; $display("FAIL break_ovr got=%0d exp=0", ov_cnt_o - ob); end
    send_rx(8'h5A, 1'b1, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rdata_o !== 8'h5A || rv_o !== 1'b1) begin
      errors++; $display("FAIL after_break got=%h/%b exp=5a/1", rdata_o, rv_o);
    end
    rr_o = 1'b1;
    @(negedge clk);
    rr_o = 1'b0;
  endtask

  task automatic test_overrun;
    int ob;
    ob = ov_cnt_o;
    send_rx(8'h11, 1'b1, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    send_rx(8'h22, 1'b1, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rdata_o !== 8'h11) begin errors++; $display("FAIL ovr_data got=%h exp=11", rdata_o); end
    checks++; if (rv_o !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", rv_o); end
    checks++; if (ov_cnt_o - ob !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt_o - ob); end
    rr_o = 1'b1;
    @(negedge clk);
    rr_o = 1'b0;
    ob = ov_cnt_o;
    send_rx(8'h11, 1'b1, 1'b1, -1);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    send_rx(8'h22, 1'b1, 1'b1, 170);
    rxd_o = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rdata_o !== 8'h22) begin errors++; $display("FAIL swap_data got=%h exp=22", rdata_o); end
    checks++; if (rv_o !== 1'b1) begin errors++; $display("FAIL swap_valid got=%b exp=1", rv_o); end
    checks++; if (ov_cnt_o - ob !== 0) begin errors++; $display("FAIL swap_ovr got=%0d exp=0", ov_cnt_o - ob); end
    rr_o = 1'b1;
    @(negedge clk);
    rr_o = 1'b0;
  endtask

  task automatic test_glitch;
    int fb;
    fb = fe_cnt_e;
    rxd_e = 1'b0;
    repeat (4) @(negedge clk);
    rxd_e = 1'b1;
    repeat (800) @(negedge clk);
    checks++; if (rv_e !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", rv_e); end
    checks++; if (fe_cnt_e - fb !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt_e - fb); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    int n, lows;
    lb_e = 1'b1;
    @(negedge clk);
    tdata_e = 8'h9E; tv_e = 1'b1;
    @(negedge clk);
    tv_e = 1'b0;
    n = 0; lows = 0;
    while (rv_e !== 1'b1 && n < 1000) begin
      if (txd_e !== 1'b1) lows++;
      n++;
      @(negedge clk);
    end
    checks++; if (rv_e !== 1'b1) begin errors++; $display("FAIL lb_valid got=%b exp=1", rv_e); end
    checks++; if (rdata_e !== 8'h9E) begin errors++; $display("FAIL lb_data got=%h exp=9e", rdata_e); end
    checks++; if (pe_e !== 1'b0) begin errors++; $display("FAIL lb_perr got=%b exp=0", pe_e); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL lb_txd_low got=%0d exp=0", lows); end
    rr_e = 1'b1;
    @(negedge clk);
    rr_e = 1'b0;
    lb_e = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_tx;
    test_back_to_back;
    test_rx_parity;
    test_frame_err;
    test_overrun;
    test_glitch;
`ifdef UART_LOOPBACK_EN
    test_loopback;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
